aer_in_receiver: RTL and testbench

Synthesizable AER input responder for the FF-STDP core. It terminates the 4-phase REQ/ACK handshake driven on `AERIN_ADDR`/`AERIN_REQ` by the spike source (host or testbench), and decodes each 12-bit address into a pixel event or a time-step marker. Decoded events are buffered in a small FIFO and handed to the neuron scheduler over a valid/ready stream. The block also tracks the time step within the current sample and flags sample completion.

---
 rtl/aer_in_receiver.sv | 180 ++++++++++++++++++
 tb/tb_aer_in_receiver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_in_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : aer_in_receiver
// Purpose  : AER input responder. Completes the 4-phase REQ/ACK handshake
//            from the spike source. It decodes each 12-bit address into a
//            pixel event or a time-step marker and buffers decoded events
//            in a first-word-fall-through FIFO. It also tracks the time step
//            within the current sample.
// Ports    : CLK, RST_N                 clock / async active-low reset
//            AERIN_ADDR, AERIN_REQ      address and request from the sender
//            AERIN_ACK                  registered acknowledge
//            EVT_VALID/EVT_READY        event stream handshake
//            EVT_IS_TICK/PIX/TSTEP      FIFO head contents
//            SAMPLE_DONE                pulse after the last marker of a sample
//            EVT_CNT                    pixel events in the current sample
//            FIFO_FULL, ADDR_ERR        status flags
// Revision : 1.0  initial release
// ============================================================================
module aer_in_receiver #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned T_STEPS    = 8,
  parameter int unsigned N_PIX      = 784
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [11:0] AERIN_ADDR,
  input  logic        AERIN_REQ,
  output logic        AERIN_ACK,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic        EVT_IS_TICK,
  output logic [9:0]  EVT_PIX,
  output logic [2:0]  EVT_TSTEP,
  output logic        SAMPLE_DONE,
  output logic [15:0] EVT_CNT,
  output logic        FIFO_FULL,
  output logic        ADDR_ERR
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [2:0]    TSTEP_LAST = 3'(T_STEPS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } state_t;

  state_t state, state_next;

  logic req_meta, req_s;
  logic accept;
  logic addr_tick, addr_pix_ok;
  logic push, pop;
  logic tick_acc, last_tick;

  logic [2:0]    tstep;
  logic [15:0]   evt_cnt;
  logic          sample_done;
  logic          addr_err;

  logic [13:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [13:0]   head;
  logic          fifo_full;

  // Two-flop synchronizer for the asynchronous request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= AERIN_REQ;
      req_s    <= req_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Full is taken from registered occupancy, so a pop in this cycle cannot
  // let a push through in the same cycle; ACK is withheld instead.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && !fifo_full) begin
          accept     = 1'b1;
          state_next = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address decode; AERIN_ADDR is stable whenever the synchronized REQ is high.
  always_comb begin
    addr_tick   = !AERIN_ADDR[11] && AERIN_ADDR[10];
    addr_pix_ok = !AERIN_ADDR[11] && !AERIN_ADDR[10] &&
                  (32'(AERIN_ADDR[9:0]) < N_PIX);
  end

  assign push      = accept && (addr_tick || addr_pix_ok);
  assign pop       = EVT_VALID && EVT_READY;
  assign tick_acc  = accept && addr_tick;
  assign last_tick = tick_acc && (tstep == TSTEP_LAST);

  // Time step, sample completion and per-sample pixel count. The count is
  // cleared on the same edge that raises SAMPLE_DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tstep       <= 3'd0;
      sample_done <= 1'b0;
      evt_cnt     <= 16'd0;
      addr_err    <= 1'b0;
    end else begin
      sample_done <= last_tick;
      if (tick_acc) begin
        tstep <= last_tick ? 3'd0 : tstep + 3'd1;
      end
      if (last_tick) begin
        evt_cnt <= 16'd0;
      end else if (accept && addr_pix_ok && (evt_cnt != 16'hFFFF)) begin
        evt_cnt <= evt_cnt + 16'd1;
      end
      if (accept && !(addr_tick || addr_pix_ok)) begin
        addr_err <= 1'b1;
      end
    end
  end

  // FIFO storage, entry = {is_tick, pix[9:0], tstep[2:0]}.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {addr_tick, (addr_tick ? 10'd0 : AERIN_ADDR[9:0]), tstep};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_full = (count == DEPTH_C);
  assign head      = mem[rd_ptr];

  // Head fields are masked while empty so outputs read 0 out of reset.
  assign EVT_VALID   = (count != '0);
  assign EVT_IS_TICK = EVT_VALID & head[13];
  assign EVT_PIX     = head[12:3] & {10{EVT_VALID}};
  assign EVT_TSTEP   = head[2:0] & {3{EVT_VALID}};

  assign AERIN_ACK   = (state == ACK_HI);
  assign SAMPLE_DONE = sample_done;
  assign EVT_CNT     = evt_cnt;
  assign FIFO_FULL   = fifo_full;
  assign ADDR_ERR    = addr_err;

endmodule
`default_nettype wire

// File: tb/tb_aer_in_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aer_in_receiver
// Purpose  : Self-checking bench for aer_in_receiver. Expected events are
//            queued when a request is raised and compared as the consumer
//            pops them.
// Revision : 1.0  initial release
// ============================================================================
module tb_aer_in_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] addr = 12'd0;
  logic        req = 1'b0;
  logic        ack;
  logic        valid;
  logic        ready = 1'b0;
  logic        is_tick;
  logic [9:0]  pix;
  logic [2:0]  tstep;
  logic        done;
  logic [15:0] cnt;
  logic        full;
  logic        err;

  always #5 clk = ~clk;

  aer_in_receiver #(
    .FIFO_DEPTH(16),
    .T_STEPS   (8),
    .N_PIX     (784)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .AERIN_ADDR (addr),
    .AERIN_REQ  (req),
    .AERIN_ACK  (ack),
    .EVT_VALID  (valid),
    .EVT_READY  (ready),
    .EVT_IS_TICK(is_tick),
    .EVT_PIX    (pix),
    .EVT_TSTEP  (tstep),
    .SAMPLE_DONE(done),
    .EVT_CNT    (cnt),
    .FIFO_FULL  (full),
    .ADDR_ERR   (err)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];
  int m_tstep = 0;
  int m_cnt = 0;
  int pops = 0;
  int done_pulses = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decode: queue what the receiver should push for address a.
  task automatic expect_event(input logic [11:0] a);
    if (a[11]) begin
      // illegal: dropped
    end else if (a[10]) begin
      exp_q.push_back({1'b1, 10'd0, 3'(m_tstep)});
      m_tstep = (m_tstep + 1) % 8;
    end else if (int'(a[9:0]) < 784) begin
      exp_q.push_back({1'b0, a[9:0], 3'(m_tstep)});
      m_cnt++;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_tstep = 0;
    m_cnt   = 0;
  endtask

  // Consumer side: compare every popped head against the scoreboard.
  always @(negedge clk) begin
    logic [13:0] e;
    if (done) done_pulses++;
    if (valid && ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event", {18'd0, is_tick, pix, tstep}, {18'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int max, output int edges);
    edges = 0;
    while (ack !== lvl && edges < max) begin
      tick();
      edges++;
    end
  endtask

  task automatic raise(input logic [11:0] a, input string tag);
    int e;
    addr = a;
    req  = 1'b1;
    expect_event(a);
    wait_ack(1'b1, 20, e);
    check({tag, "_ack_rise"}, e, 3);
  endtask

  task automatic release_req(input string tag);
    int e;
    req = 1'b0;
    wait_ack(1'b0, 20, e);
    check({tag, "_ack_fall"}, e, 3);
  endtask

  task automatic send(input logic [11:0] a, input string tag);
    raise(a, tag);
    release_req(tag);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !valid) break;
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", valid, 0);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    req   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    clear_model();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int c0;

    // Reset state
    tick();
    tick();
    check("rst_ack", ack, 0);
    check("rst_valid", valid, 0);
    check("rst_is_tick", is_tick, 0);
    check("rst_pix", pix, 0);
    check("rst_tstep", tstep, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Single pixel; entry is visible right after acceptance
    raise(12'h005, "single");
    check("single_cnt", cnt, 1);
    check("single_valid", valid, 1);
    check("single_pix", pix, 5);
    check("single_is_tick", is_tick, 0);
    check("single_tstep", tstep, 0);
    release_req("single");
    drain();

    // Reset in the middle of a handshake, REQ held through it
    raise(12'h007, "rstmid");
    check("rstmid_valid_before", valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_ack_low", ack, 0);
    check("rstmid_fifo_empty", valid, 0);
    check("rstmid_cnt_clear", cnt, 0);
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    expect_event(12'h007);
    wait_ack(1'b1, 20, e);
    check("rstmid_reack_edges", e, 3);
    check("rstmid_cnt", cnt, 1);
    release_req("rstmid");
    drain();

    // Full sample: 8 x (0, 100, 783, marker)
    do_reset();
    ready       = 1'b1;
    pops        = 0;
    done_pulses = 0;
    for (int s = 0; s < 8; s++) begin
      send(12'd0,   "samp_pix0");
      send(12'd100, "samp_pix100");
      send(12'd783, "samp_pix783");
      if (s < 7) begin
        send(12'h4FF, "samp_tick");
        check("samp_no_done_yet", done_pulses, 0);
      end else begin
        check("samp_cnt_24", cnt, 24);
        raise(12'h4FF, "samp_last");
        check("samp_done_pulse", done, 1);
        check("samp_cnt_cleared", cnt, 0);
        tick();
        check("samp_done_width", done, 0);
        release_req("samp_last");
      end
    end
    drain();
    check("samp_pops", pops, 32);
    check("samp_done_count", done_pulses, 1);
    check("samp_cnt_after", cnt, 0);

    // Backpressure: 16 fill the FIFO, the 17th is held off
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send(12'(i * 10), "bp_fill");
    check("bp_full", full, 1);
    addr = 12'd300;
    req  = 1'b1;
    expect_event(12'd300);
    repeat (8) tick();
    check("bp_17_held", ack, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_pop_not_full", full, 0);
    check("bp_ack_not_same_cycle", ack, 0);
    wait_ack(1'b1, 20, e);
    check("bp_17_acked_edges", e, 1);
    check("bp_full_again", full, 1);
    release_req("bp17");
    drain();

    // Pop at full, then push and pop on the same edge
    for (int i = 0; i < 16; i++) send(12'(i + 500), "pp_fill");
    addr = 12'd400;
    req  = 1'b1;
    expect_event(12'd400);
    repeat (5) tick();
    check("pp_held", ack, 0);
    check("pp_full", full, 1);
    ready = 1'b1;
    tick();
    check("pp_not_acked_on_pop", ack, 0);
    tick();
    ready = 1'b0;
    check("pp_acked_next", ack, 1);
    check("pp_occupancy_kept", full, 0);
    release_req("pp");
    drain();

    // Illegal addresses
    c0 = int'(cnt);
    send(12'h310, "ill_784");
    check("ill_err_784", err, 1);
    send(12'h800, "ill_bit11");
    check("ill_err_bit11", err, 1);
    check("ill_no_push", valid, 0);
    check("ill_cnt_unchanged", cnt, c0);
    send(12'h00A, "ill_after");
    check("ill_err_sticky", err, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
